// File: rtl/ram_pkg.sv
// Shared widths and FSM states for the burst RAM controller.
// Imported by the controller, its read slice, the RAM and benches.
package ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/ram.sv
// Single-port RAM: synchronous write, combinational read.
// Ports: clk, write_en, read_en, addr, data_in, data_out.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (write_en) mem[addr] <= data_in;
  end

  assign data_out = read_en ? mem[addr] : '0;

endmodule

// File: rtl/ram_rd_slice.sv
// Read output register: valid/data hold with load and clear.
// Ports: clk, rst_n, load, clear, din -> valid, data.
module ram_rd_slice
  import ram_pkg::*;
#(
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller: cmd -> write/read bursts on a 1-port RAM.
// Ports: cmd_*, wr_* stream, rd_* stream, done/busy, mem_*.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              wr_hs;
  logic              rd_issue;
  logic              rd_hs;
  logic              last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign wr_hs     = wr_ready && wr_valid;
  // Issue only when the output slot is free or being drained.
  assign rd_issue  = (state == READ) && (!rd_valid || rd_ready);
  assign rd_hs     = rd_valid && rd_ready;
  assign last      = (cnt_q == '0);

  assign mem_write_en = wr_hs;
  assign mem_read_en  = rd_issue;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            state  <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - ADDR_W'(1);
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - ADDR_W'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A handshake without a same-cycle issue empties the slot.
  ram_rd_slice #(
    .DATA_W(DATA_W)
  ) u_rd_slice (
    .clk  (clk),
    .rst_n(rst_n),
    .load (rd_issue),
    .clear(rd_hs && !rd_issue),
    .din  (mem_rdata),
    .valid(rd_valid),
    .data (rd_data)
  );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl + ram: directed and random bursts
// checked each cycle against a transaction-level model.
module tb_ram_burst_ctrl;
  import ram_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, busy;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data),
    .done(done), .busy(busy),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk(clk), .write_en(mem_write_en),
    .read_en(mem_read_en), .addr(mem_addr),
    .data_in(mem_wdata), .data_out(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Transaction-level model state.
  logic [DW-1:0] mm [0:255];
  logic [DW-1:0] exp_q [$];
  bit            act, m_wr, done_due, iss_prev, hold_prev;
  int            w_rem, r_left;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] prev_rd;
  int            done_cnt = 0;

  always @(negedge clk) begin
    bit a0, mre;
    if (!rst_n) begin
      act = 0; done_due = 0; iss_prev = 0; hold_prev = 0;
      exp_q.delete();
    end else begin
      a0 = act;
      chk("cmd_ready", cmd_ready, !a0);
      chk("busy", busy, a0);
      chk("done", done, done_due);
      if (done) done_cnt++;
      done_due = 0;
      chk("wr_ready", wr_ready, a0 && m_wr);
      chk("mem_write_en", mem_write_en, a0 && m_wr && wr_valid);
      chk("rd_valid", rd_valid, iss_prev || hold_prev);
      if (hold_prev) chk("rd_hold", rd_data, prev_rd);
      mre = a0 && !m_wr && r_left > 0 && (!rd_valid || rd_ready);
      chk("mem_read_en", mem_read_en, mre);
      if (a0 && m_wr && wr_valid) begin
        chk("wr_addr", mem_addr, w_addr);
        chk("wr_data", mem_wdata, wr_data);
        mm[w_addr] = wr_data;
        w_addr++;
        w_rem--;
        if (w_rem == 0) begin act = 0; done_due = 1; end
      end
      if (mre) begin
        chk("rd_addr", mem_addr, r_addr);
        r_addr++;
        r_left--;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rd_data", rd_data, exp_q.pop_front());
          if (exp_q.size() == 0 && r_left == 0) begin
            act = 0; done_due = 1;
          end
        end
      end
      iss_prev  = mre;
      hold_prev = rd_valid && !rd_ready;
      prev_rd   = rd_data;
      if (!a0 && cmd_valid && cmd_ready) begin
        act    = 1;
        m_wr   = cmd_write;
        w_addr = cmd_addr;
        r_addr = cmd_addr;
        w_rem  = int'(cmd_len) + 1;
        r_left = cmd_write ? 0 : int'(cmd_len) + 1;
        if (!cmd_write)
          for (int i = 0; i <= int'(cmd_len); i++)
            exp_q.push_back(mm[AW'(int'(cmd_addr) + i)]);
      end
    end
  end

  logic [DW-1:0] wdat [0:255];
  logic [DW-1:0] cap_q [$];
  int            cap_c [$];
  int            acc_cyc;

  // Caller must be at posedge+1. vm: 0 const wr_valid, 1 random.
  // rm: 0 rd_ready high, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_burst(input bit wr, input logic [AW-1:0] a,
                           input logic [AW-1:0] l,
                           input int vm, input int rm);
    int  beat = 0;
    int  k = 0;
    int  cyc = 0;
    bit  acc = 0;
    bit  acc_old = 0;
    bit  fin = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    while (!fin && cyc < 3000) begin
      if (wr && acc)
        wr_valid = beat <= int'(l) &&
                   (vm == 0 || $urandom_range(0, 2) != 0);
      else
        wr_valid = (vm != 0) && ($urandom_range(0, 1) == 1);
      wr_data = (beat <= int'(l)) ? wdat[beat] : $urandom;
      case (rm)
        0: rd_ready = 1'b1;
        1: rd_ready = ((k + 2) % 3 == 0);
        default: rd_ready = $urandom_range(0, 1) == 1;
      endcase
      @(negedge clk);
      if (acc_old && done) fin = 1;
      if (wr_valid && wr_ready) beat++;
      if (!acc && cmd_ready) begin acc = 1; acc_cyc = cyc_n; end
      if (rd_valid && rd_ready) begin
        cap_q.push_back(rd_data);
        cap_c.push_back(cyc_n);
      end
      @(posedge clk); #1;
      if (acc) cmd_valid = 0;
      acc_old = acc;
      if (acc) k++;
      cyc++;
    end
    chk("burst_done", fin, 1);
    cmd_valid = 0; wr_valid = 0; rd_ready = 0;
  endtask

  task automatic chk_cap4(input string nm, input logic [DW-1:0] b0,
                          input logic [DW-1:0] b1,
                          input logic [DW-1:0] b2,
                          input logic [DW-1:0] b3);
    logic [DW-1:0] e [4];
    e = '{b0, b1, b2, b3};
    chk({nm, "_cnt"}, cap_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk(nm, (cap_q.size() > i) ? cap_q[i] : 'x, e[i]);
  endtask

  int snap;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Full 256-beat write fills RAM and model.
    for (int i = 0; i < 256; i++) wdat[i] = i * 3 + 7;
    run_burst(1, 8'h00, 8'hFF, 1, 0);
    chk("full_ram_ff", u_ram.mem[255], 32'd772);

    // Write 0x10, 4 beats.
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + i;
    snap = done_cnt;
    run_burst(1, 8'h10, 8'd3, 0, 0);
    chk("wr_done_once", done_cnt - snap, 1);
    chk("ram_10", u_ram.mem[8'h10], 32'hA0);
    chk("ram_13", u_ram.mem[8'h13], 32'hA3);

    // Read back at full rate.
    cap_q.delete(); cap_c.delete();
    snap = done_cnt;
    run_burst(0, 8'h10, 8'd3, 0, 0);
    chk("rd_done_once", done_cnt - snap, 1);
    chk_cap4("rd_10", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    if (cap_c.size() == 4) begin
      chk("rd_first_lat", cap_c[0] - acc_cyc, 2);
      for (int i = 1; i < 4; i++)
        chk("rd_consec", cap_c[i] - cap_c[0], i);
    end

    // Address wrap.
    for (int i = 0; i < 4; i++) wdat[i] = i + 1;
    run_burst(1, 8'hFE, 8'd3, 0, 0);
    chk("ram_fe", u_ram.mem[8'hFE], 32'd1);
    chk("ram_ff", u_ram.mem[8'hFF], 32'd2);
    chk("ram_00", u_ram.mem[8'h00], 32'd3);
    chk("ram_01", u_ram.mem[8'h01], 32'd4);
    cap_q.delete(); cap_c.delete();
    run_burst(0, 8'hFE, 8'd3, 0, 0);
    chk_cap4("rd_wrap", 32'd1, 32'd2, 32'd3, 32'd4);

    // Backpressure.
    cap_q.delete(); cap_c.delete();
    run_burst(0, 8'h10, 8'd3, 0, 1);
    chk_cap4("rd_stall", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Reset in the 3rd beat of an 8-beat write.
    for (int i = 0; i < 8; i++) wdat[i] = 32'hEE00 + i;
    run_burst(1, 8'h40, 8'd7, 0, 0);
    for (int i = 0; i < 8; i++) wdat[i] = 32'h50 + i;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h40; cmd_len = 8'd7;
    @(posedge clk); #1;
    cmd_valid = 0; wr_valid = 1; wr_data = wdat[0];
    @(posedge clk); #1; wr_data = wdat[1];
    @(posedge clk); #1; wr_data = wdat[2];
    snap = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wen", mem_write_en, 0);
    chk("arst_wr_ready", wr_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_valid", rd_valid, 0);
    wr_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, snap);
    chk("abort_40", u_ram.mem[8'h40], 32'h50);
    chk("abort_41", u_ram.mem[8'h41], 32'h51);
    chk("abort_42", u_ram.mem[8'h42], 32'hEE02);
    run_burst(0, 8'h40, 8'd7, 1, 2);

    // Random bursts.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 256; i++) wdat[i] = $urandom;
      run_burst($urandom_range(0, 1) == 1, AW'($urandom),
                ($urandom_range(0, 7) == 0) ?
                  AW'($urandom_range(0, 63)) :
                  AW'($urandom_range(0, 7)),
                $urandom_range(0, 1), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, RAM address width; the RAM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, 32, RAM word width.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port cmd_valid  in  1  burst command present.
REQ-006 Port cmd_ready  out  1  controller able to accept a command.
REQ-007 Port cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 Port cmd_addr  in  ADDR_W  burst start address.
REQ-009 Port cmd_len  in  ADDR_W  beat count minus 1 (0 = 1 beat, 255 = 256 beats).
REQ-010 Port wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_W  write-data stream.
REQ-011 Port rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  read-data stream.
REQ-012 Port done  out  1  one-cycle pulse on burst completion.
REQ-013 Port busy  out  1  high whenever the state is not IDLE.
REQ-014 Port mem_write_en / mem_read_en / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  drive the RAM write_en, read_en, addr and data_in inputs.
REQ-015 Port mem_rdata  in  DATA_W  RAM data_out; combinational in mem_addr while mem_read_en is high.

Function
REQ-016 The FSM SHALL have four states (IDLE, WRITE, READ, DRAIN), with cmd_ready = (state == IDLE).
REQ-017 On a cmd_valid && cmd_ready edge, the block SHALL latch cmd_addr into addr_q and cmd_len into cnt_q, then go to WRITE if cmd_write is 1, else READ.
REQ-018 In WRITE: wr_ready = 1; mem_write_en = wr_valid; mem_addr = addr_q; mem_wdata = wr_data (all combinational); mem_read_en = 0.
REQ-019 Each wr_valid && wr_ready edge SHALL write one word, increment addr_q modulo 2**ADDR_W (255 -> 0), and decrement cnt_q.
REQ-020 A write handshake with cnt_q == 0 SHALL return the FSM to IDLE and pulse done for the following cycle.
REQ-021 In READ, a read issues when !rd_valid || rd_ready: mem_read_en = 1, mem_addr = addr_q, and rd_data <= mem_rdata, rd_valid <= 1 at the edge; addr_q increments with the same wrap rule and cnt_q decrements.
REQ-022 The read latency SHALL be 1 cycle from issue to rd_valid; reads SHALL sustain 1 beat/cycle while rd_ready is held high.
REQ-023 Under backpressure (rd_valid && !rd_ready), no read SHALL issue, mem_read_en SHALL be 0, and rd_data SHALL hold stable.
REQ-024 The READ issue with cnt_q == 0 SHALL move the FSM to DRAIN; in DRAIN, the rd_valid && rd_ready handshake SHALL clear rd_valid, return the FSM to IDLE, and pulse done in the next cycle.
REQ-025 rd_valid SHALL clear on any rd_ready handshake that has no simultaneous issue.
REQ-026 mem_write_en and mem_read_en SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DRAIN.
REQ-027 A new command SHALL be acceptable in the same cycle that done is high.
REQ-028 wr_valid in IDLE, READ or DRAIN SHALL be ignored, with wr_ready = 0.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state to IDLE; addr_q, cnt_q and rd_data to 0; rd_valid, done and busy to 0.
REQ-030 A reset mid-burst SHALL abort the burst with no done pulse; RAM contents already written SHALL remain untouched.
REQ-031 After reset, cmd_ready SHALL be 1 from the first cycle that rst_n is high.

Structure
REQ-032 Package ram_pkg SHALL hold ADDR_W and DATA_W defaults and the FSM state enumeration, shared with the ram block and benches.
REQ-033 The read output register SHALL be one sub-module, ram_rd_slice (valid/data hold register with load and clear); everything else stays in ram_burst_ctrl.

Verification
REQ-034 Bench SHALL instantiate ram_burst_ctrl connected to ram (clk, write_en, read_en, addr, data_in, data_out), clock period 10.
REQ-035 Write burst addr 0x10, len 3, data 0xA0..0xA3, wr_valid constant -> RAM[0x10..0x13] = 0xA0..0xA3, done 1 cycle after 4th beat.
REQ-036 Read burst addr 0x10, len 3, rd_ready = 1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, first 1 cycle after accept, done once.
REQ-037 Write addr 0xFE, len 3, data 1..4, then read back -> RAM[0xFE]=1, [0xFF]=2, [0x00]=3, [0x01]=4.
REQ-038 Read 4 beats with rd_ready toggling 1,0,0,1,... -> data order intact, rd_data stable while stalled, no mem_read_en during stall.
REQ-039 rst_n low during 3rd beat of an 8-beat write -> outputs 0 asynchronously, no done, only the first 2 words written, then new command accepted after release.
